// File: rtl/paquete_uart_pkg.sv
// Shared types and constants for the inter-FPGA serial receive stage.
package paquete_uart_pkg;

   typedef enum logic [1:0] {
      ESPERA = 2'd0,
      INICIO = 2'd1,
      DATOS  = 2'd2,
      PARADA = 2'd3
   } estado_t;

   localparam int   ANCHO_DATO     = 8;
   localparam logic LINEA_INACTIVA = 1'b1;

   // Packet layout: {destination, data}
   localparam int DESTINO_MSB = 7;
   localparam int DESTINO_LSB = 4;
   localparam int DATO_MSB    = 3;
   localparam int DATO_LSB    = 0;

   function automatic logic [DESTINO_MSB-DESTINO_LSB:0] destinoPaquete(input logic [ANCHO_DATO-1:0] paquete);
      return paquete[DESTINO_MSB:DESTINO_LSB];
   endfunction

   function automatic logic [DATO_MSB-DATO_LSB:0] datoPaquete(input logic [ANCHO_DATO-1:0] paquete);
      return paquete[DATO_MSB:DATO_LSB];
   endfunction

endpackage

// File: rtl/receptor_uart_if.sv
// Link between the serial line, the receiver and the packet processor.
interface receptor_uart_if;
   import paquete_uart_pkg::*;

   logic                  lineaRecepcionBits;
   logic [ANCHO_DATO-1:0] bitsRecibidos;
   logic                  recepcionFinalizada;
   logic                  errorTrama;
   logic                  ocupado;

   // Receiver side
   modport master (
      input  lineaRecepcionBits,
      output bitsRecibidos,
      output recepcionFinalizada,
      output errorTrama,
      output ocupado
   );

   // Line source / packet consumer side
   modport slave (
      output lineaRecepcionBits,
      input  bitsRecibidos,
      input  recepcionFinalizada,
      input  errorTrama,
      input  ocupado
   );

endinterface

// File: rtl/generador_ticks_muestreo.sv
// Oversampling tick divider; clearing it realigns the sample phase.
module generador_ticks_muestreo #(
   parameter int CICLOS_POR_MUESTRA = 1
) (
   input  logic reloj,
   input  logic reinicio,
   input  logic limpiar,
   output logic tick
);

   localparam int ANCHO = (CICLOS_POR_MUESTRA > 1) ? $clog2(CICLOS_POR_MUESTRA) : 1;
   localparam logic [ANCHO-1:0] TERMINAL = ANCHO'(CICLOS_POR_MUESTRA - 1);

   logic [ANCHO-1:0] cuenta;

   // Free-running count 0..CICLOS_POR_MUESTRA-1, restarted by limpiar
   always_ff @(posedge reloj or negedge reinicio) begin
      if (!reinicio) begin
         cuenta <= '0;
      end else if (limpiar || (cuenta == TERMINAL)) begin
         cuenta <= '0;
      end else begin
         cuenta <= cuenta + ANCHO'(1);
      end
   end

   assign tick = (cuenta == TERMINAL);

endmodule

// File: rtl/receptor_uart.sv
// 8N1 serial receiver producing {destination, data} packets for the processor.
module receptor_uart
   import paquete_uart_pkg::*;
#(
   parameter int FRECUENCIA_RELOJ = 50000000,
   parameter int BAUDIOS          = 9600,
   parameter int SOBREMUESTREO    = 16
) (
   input  logic            reloj,
   input  logic            reinicio,
   receptor_uart_if.master enlace
);

   localparam int CICLOS_POR_MUESTRA = FRECUENCIA_RELOJ / (BAUDIOS * SOBREMUESTREO);
   localparam int ANCHO_MUESTRA      = $clog2(SOBREMUESTREO);
   localparam int ANCHO_BITS         = $clog2(ANCHO_DATO);

   localparam logic [ANCHO_MUESTRA-1:0] MUESTRA_MITAD_INICIO = ANCHO_MUESTRA'(SOBREMUESTREO / 2 - 1);
   localparam logic [ANCHO_MUESTRA-1:0] MUESTRA_FINAL        = ANCHO_MUESTRA'(SOBREMUESTREO - 1);
   localparam logic [ANCHO_BITS-1:0]    ULTIMO_BIT           = ANCHO_BITS'(ANCHO_DATO - 1);

   logic [1:0] sincronizador;
   logic       lineaPrevia;
   logic [2:0] llenado;
   logic       lineaSincronizada;
   logic       flancoBajada;
   logic       tick;
   logic       limpiar;

   estado_t                estado, estadoSig;
   logic [ANCHO_MUESTRA-1:0] cuentaMuestras, cuentaMuestrasSig;
   logic [ANCHO_BITS-1:0]    cuentaBits, cuentaBitsSig;
   logic [ANCHO_DATO-1:0]    desplazamiento, desplazamientoSig;
   logic [ANCHO_DATO-1:0]    datoRecibido, datoRecibidoSig;
   logic                     finalizada, finalizadaSig;
   logic                     errorDetectado, errorDetectadoSig;

   assign lineaSincronizada = sincronizador[1];
   // llenado keeps the reset-time idle values of the pipeline from looking
   // like a real 1->0 transition when the line is already low at release.
   assign flancoBajada = llenado[2] & lineaPrevia & ~lineaSincronizada;

   // Two-flop synchronizer plus edge-detection flop
   always_ff @(posedge reloj or negedge reinicio) begin
      if (!reinicio) begin
         sincronizador <= {2{LINEA_INACTIVA}};
         lineaPrevia   <= LINEA_INACTIVA;
         llenado       <= '0;
      end else begin
         sincronizador <= {sincronizador[0], enlace.lineaRecepcionBits};
         lineaPrevia   <= lineaSincronizada;
         llenado       <= {llenado[1:0], 1'b1};
      end
   end

   generador_ticks_muestreo #(
      .CICLOS_POR_MUESTRA(CICLOS_POR_MUESTRA)
   ) generadorTicks (
      .reloj   (reloj),
      .reinicio(reinicio),
      .limpiar (limpiar),
      .tick    (tick)
   );

   // FSM, counters, shift register and output registers
   always_ff @(posedge reloj or negedge reinicio) begin
      if (!reinicio) begin
         estado         <= ESPERA;
         cuentaMuestras <= '0;
         cuentaBits     <= '0;
         desplazamiento <= '0;
         datoRecibido   <= '0;
         finalizada     <= 1'b0;
         errorDetectado <= 1'b0;
      end else begin
         estado         <= estadoSig;
         cuentaMuestras <= cuentaMuestrasSig;
         cuentaBits     <= cuentaBitsSig;
         desplazamiento <= desplazamientoSig;
         datoRecibido   <= datoRecibidoSig;
         finalizada     <= finalizadaSig;
         errorDetectado <= errorDetectadoSig;
      end
   end

   // Next-state and datapath decisions, all sampled on mid-bit ticks
   always_comb begin
      estadoSig         = estado;
      cuentaMuestrasSig = cuentaMuestras;
      cuentaBitsSig     = cuentaBits;
      desplazamientoSig = desplazamiento;
      datoRecibidoSig   = datoRecibido;
      finalizadaSig     = 1'b0;
      errorDetectadoSig = 1'b0;
      limpiar           = 1'b0;

      unique case (estado)
         ESPERA: begin
            if (flancoBajada) begin
               estadoSig         = INICIO;
               cuentaMuestrasSig = '0;
               limpiar           = 1'b1;
            end
         end
         INICIO: begin
            if (tick) begin
               if (cuentaMuestras == MUESTRA_MITAD_INICIO) begin
                  cuentaMuestrasSig = '0;
                  cuentaBitsSig     = '0;
                  estadoSig         = lineaSincronizada ? ESPERA : DATOS;
               end else begin
                  cuentaMuestrasSig = cuentaMuestras + ANCHO_MUESTRA'(1);
               end
            end
         end
         DATOS: begin
            if (tick) begin
               if (cuentaMuestras == MUESTRA_FINAL) begin
                  cuentaMuestrasSig = '0;
                  desplazamientoSig = {lineaSincronizada, desplazamiento[ANCHO_DATO-1:1]};
                  if (cuentaBits == ULTIMO_BIT) begin
                     estadoSig = PARADA;
                  end else begin
                     cuentaBitsSig = cuentaBits + ANCHO_BITS'(1);
                  end
               end else begin
                  cuentaMuestrasSig = cuentaMuestras + ANCHO_MUESTRA'(1);
               end
            end
         end
         PARADA: begin
            if (tick) begin
               if (cuentaMuestras == MUESTRA_FINAL) begin
                  cuentaMuestrasSig = '0;
                  estadoSig         = ESPERA;
                  if (lineaSincronizada) begin
                     datoRecibidoSig = desplazamiento;
                     finalizadaSig   = 1'b1;
                  end else begin
                     errorDetectadoSig = 1'b1;
                  end
               end else begin
                  cuentaMuestrasSig = cuentaMuestras + ANCHO_MUESTRA'(1);
               end
            end
         end
         default: estadoSig = ESPERA;
      endcase
   end

   assign enlace.bitsRecibidos       = datoRecibido;
   assign enlace.recepcionFinalizada = finalizada;
   assign enlace.errorTrama          = errorDetectado;
   assign enlace.ocupado             = (estado != ESPERA);

endmodule

// File: tb/tb_receptor_uart.sv
// Scoreboard bench for receptor_uart at 4 clocks per tick, 64 clocks per bit.
module tb_receptor_uart;
   import paquete_uart_pkg::*;

   localparam int unsigned CICLOS_BIT = 64;
   localparam int unsigned LAT_MIN    = 609;
   localparam int unsigned LAT_MAX    = 613;

   logic reloj    = 1'b0;
   logic reinicio = 1'b0;

   receptor_uart_if bus ();

   receptor_uart #(
      .FRECUENCIA_RELOJ(640000),
      .BAUDIOS         (10000),
      .SOBREMUESTREO   (16)
   ) dut (
      .reloj   (reloj),
      .reinicio(reinicio),
      .enlace  (bus)
   );

   always #5 reloj = ~reloj;

   int unsigned ciclo = 0;
   always @(posedge reloj) ciclo <= ciclo + 1;

   typedef struct {
      bit          esError;
      logic [7:0]  valor;
      int unsigned cicloFlanco;
   } esperado_t;

   esperado_t  cola[$];
   esperado_t  eMon;
   logic [7:0] ultimoBueno = 8'h00;
   int         comparaciones = 0;
   int         fallos = 0;

   task automatic comparar(input string nombre, input logic [31:0] actual, input logic [31:0] requerido);
      comparaciones++;
      if (actual !== requerido) begin
         fallos++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nombre, actual, requerido, $time);
      end
   endtask

   task automatic rango(input string nombre, input int unsigned actual, input int unsigned mn, input int unsigned mx);
      comparaciones++;
      if (actual < mn || actual > mx) begin
         fallos++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", nombre, actual, mn, mx, $time);
      end
   endtask

   // Hold the line at v for n clocks; always called at posedge+1
   task automatic nivel(input logic v, input int unsigned n);
      bus.lineaRecepcionBits = v;
      repeat (n) @(posedge reloj);
      #1;
   endtask

   // Full 8N1 frame; the expected outcome depends only on the stop bit
   task automatic enviarTrama(input logic [7:0] valor, input logic bitParada);
      esperado_t  e;
      logic [7:0] t;
      e.esError     = !bitParada;
      e.valor       = valor;
      e.cicloFlanco = ciclo;
      cola.push_back(e);
      nivel(1'b0, CICLOS_BIT);
      for (int i = 0; i < 8; i++) begin
         t = valor >> i;
         nivel(t[0], CICLOS_BIT);
      end
      nivel(bitParada, CICLOS_BIT);
   endtask

   // Monitor: every strobe must match the oldest expected frame outcome
   always @(negedge reloj) begin
      if (reinicio && (bus.recepcionFinalizada || bus.errorTrama)) begin
         comparar("strobes_exclusive", {31'd0, bus.recepcionFinalizada & bus.errorTrama}, 32'd0);
         if (cola.size() == 0) begin
            comparar("unexpected_strobe", {30'd0, bus.recepcionFinalizada, bus.errorTrama}, 32'd0);
         end else begin
            eMon = cola.pop_front();
            comparar("strobe_kind", {30'd0, bus.recepcionFinalizada, bus.errorTrama},
                     eMon.esError ? 32'd1 : 32'd2);
            if (!eMon.esError) ultimoBueno = eMon.valor;
            comparar("bitsRecibidos", {24'd0, bus.bitsRecibidos}, {24'd0, ultimoBueno});
            rango("strobe_latency", ciclo - eMon.cicloFlanco, LAT_MIN, LAT_MAX);
            comparar("ocupado_at_strobe", {31'd0, bus.ocupado}, 32'd0);
         end
      end
   end

   initial begin
      int unsigned gap;
      logic [7:0]  v;
      logic        parada;

      bus.lineaRecepcionBits = 1'b1;
      repeat (3) @(posedge reloj);
      #1;
      comparar("reset_bits", {24'd0, bus.bitsRecibidos}, 32'd0);
      comparar("reset_fin", {31'd0, bus.recepcionFinalizada}, 32'd0);
      comparar("reset_err", {31'd0, bus.errorTrama}, 32'd0);
      comparar("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
      reinicio = 1'b1;
      nivel(1'b1, 10);

      // Basic frame
      enviarTrama(8'hA5, 1'b1);
      nivel(1'b1, 20);

      // Short glitch: rejected at mid start bit
      nivel(1'b0, 10);
      comparar("glitch_ocupado_high", {31'd0, bus.ocupado}, 32'd1);
      nivel(1'b0, 10);
      nivel(1'b1, 20);
      comparar("glitch_ocupado_low", {31'd0, bus.ocupado}, 32'd0);
      comparar("glitch_bits_held", {24'd0, bus.bitsRecibidos}, 32'h0000_00A5);

      // Framing error then recovery
      enviarTrama(8'h3C, 1'b0);
      nivel(1'b1, 10);
      enviarTrama(8'h7E, 1'b1);
      nivel(1'b1, 10);

      // Back-to-back, no idle
      enviarTrama(8'h01, 1'b1);
      enviarTrama(8'hFE, 1'b1);
      nivel(1'b1, 10);

      // Asynchronous reset in the middle of 0x55 (LSB first: 1,0,1,0,1,0,1,0)
      nivel(1'b0, CICLOS_BIT);
      nivel(1'b1, CICLOS_BIT);
      nivel(1'b0, CICLOS_BIT);
      nivel(1'b1, CICLOS_BIT);
      nivel(1'b0, 32);
      #3;
      reinicio = 1'b0;
      #1;
      ultimoBueno = 8'h00;
      comparar("async_reset_bits", {24'd0, bus.bitsRecibidos}, 32'd0);
      comparar("async_reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
      comparar("async_reset_fin", {31'd0, bus.recepcionFinalizada}, 32'd0);
      comparar("async_reset_err", {31'd0, bus.errorTrama}, 32'd0);
      @(posedge reloj);
      #1;
      nivel(1'b0, 31);
      nivel(1'b1, CICLOS_BIT);
      nivel(1'b0, CICLOS_BIT);
      nivel(1'b1, CICLOS_BIT);
      nivel(1'b0, 32);
      reinicio = 1'b1;
      nivel(1'b0, 32);
      nivel(1'b1, 164);
      comparar("after_reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
      comparar("after_reset_bits", {24'd0, bus.bitsRecibidos}, 32'd0);
      enviarTrama(8'h99, 1'b1);
      nivel(1'b1, 10);

      // Line held low across reset release: needs a real high-then-low edge
      nivel(1'b0, 10);
      reinicio = 1'b0;
      ultimoBueno = 8'h00;
      nivel(1'b0, 5);
      reinicio = 1'b1;
      nivel(1'b0, 100);
      comparar("low_release_ocupado", {31'd0, bus.ocupado}, 32'd0);
      comparar("low_release_bits", {24'd0, bus.bitsRecibidos}, 32'd0);
      nivel(1'b1, CICLOS_BIT);
      enviarTrama(8'h42, 1'b1);
      nivel(1'b1, 10);

      // Random frames, random stop bits and gaps (a high level is needed after an error)
      for (int n = 0; n < 20; n++) begin
         v      = 8'($urandom_range(0, 255));
         parada = ($urandom_range(0, 3) != 0);
         enviarTrama(v, parada);
         gap = parada ? $urandom_range(0, 40) : $urandom_range(4, 40);
         if (gap > 0) nivel(1'b1, gap);
      end
      nivel(1'b1, 20);

      for (int k = 0; k < 1000 && cola.size() != 0; k++) @(posedge reloj);
      comparar("scoreboard_drained", cola.size(), 32'd0);
      comparar("final_ocupado", {31'd0, bus.ocupado}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", comparaciones, fallos);
      $finish;
   end

endmodule

// File: doc/receptor_uart.md
Name: receptor_uart

Overview:
- Serial receive stage that sits directly upstream of the packet processor on each of the three inter-FPGA links (A/B/C).
- Converts one asynchronous 8N1 line (idle high, LSB first) into an 8-bit packet {destination[7:4], data[3:0]}.
- Emits a one-cycle completion strobe that the processor consumes.
- Three instances per FPGA, one per link.

Parameters:
FRECUENCIA_RELOJ, 50000000, system clock frequency in Hz
BAUDIOS, 9600, line bit rate
SOBREMUESTREO, 16, samples per bit; must be even and at least 4
CICLOS_POR_MUESTRA (localparam), FRECUENCIA_RELOJ/(BAUDIOS*SOBREMUESTREO), clocks per sample tick; integer division, must be at least 1

Ports:
reloj  input  1  system clock, rising edge
reinicio  input  1  asynchronous active-low reset
lineaRecepcionBits  input  1  raw serial line, asynchronous to reloj
bitsRecibidos  output  8  last correctly framed byte, held until the next good frame
recepcionFinalizada  output  1  one-cycle strobe, asserted when bitsRecibidos updates
errorTrama  output  1  one-cycle strobe on a stop-bit violation
ocupado  output  1  high whenever the FSM is not in ESPERA

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reinicio low). All state clears immediately, including mid-frame:
  - bitsRecibidos=8'h00, recepcionFinalizada=0, errorTrama=0, ocupado=0, FSM=ESPERA.
  - Synchronizer flops reset to 1 (idle).
- Input path: 2-flop synchronizer feeds a third flop used for edge detection. Only the synchronized value is ever sampled.
- Tick divider:
  - Counts 0..CICLOS_POR_MUESTRA-1 and pulses tick on the terminal count.
  - Cleared on the cycle a start edge is detected, so sample phase is aligned to the edge.
- Sample counter: counts ticks 0..SOBREMUESTREO-1 within a bit. Bit counter: 0..7.
- FSM ESPERA:
  - Synchronized falling edge (previous 1, current 0) -> INICIO; clear divider and sample counter.
  - A line held low out of reset does not start a frame, because an edge is required.
- FSM INICIO: at tick SOBREMUESTREO/2-1 (mid start bit):
  - Line 0 -> DATOS; clear sample and bit counters.
  - Line 1 -> ESPERA (glitch rejected, no strobe).
- FSM DATOS:
  - At every tick with sample counter = SOBREMUESTREO-1 (mid bit), shift the line value into the shift register MSB, so LSB is received first.
  - After bit 7 -> PARADA.
- FSM PARADA: at mid stop bit:
  - Line 1: load bitsRecibidos from the shift register, pulse recepcionFinalizada for exactly one clock (the cycle after the sample), -> ESPERA.
  - Line 0: pulse errorTrama for one clock, leave bitsRecibidos unchanged, -> ESPERA.
  - After a framing error, a new frame requires the line to return high and fall again (break condition ignored).
- Back-to-back frames:
  - ESPERA is re-entered at mid stop bit, so a start edge arriving half a bit later is caught.
  - No idle time between frames is required.
- Latency: the strobe occurs (SOBREMUESTREO/2 + 9*SOBREMUESTREO)*CICLOS_POR_MUESTRA clocks after edge detection, +1 for registering the strobe. Edge detection itself is 2-3 clocks after the raw edge.
- recepcionFinalizada and errorTrama are never high in the same cycle.
- ocupado is 1 in INICIO/DATOS/PARADA.

Decomposition:
- Package paquete_uart_pkg holds:
  - the state enum (ESPERA, INICIO, DATOS, PARADA), 2 bits;
  - ANCHO_DATO=8, LINEA_INACTIVA=1'b1;
  - packet field slices: destination [7:4], data [3:0].
- Sub-module generador_ticks_muestreo: parameter CICLOS_POR_MUESTRA; ports reloj, reinicio, limpiar, tick.
- The FSM, shift register and synchronizer stay in receptor_uart.

Test Plan:
All scenarios use FRECUENCIA_RELOJ=640000, BAUDIOS=10000, SOBREMUESTREO=16, which gives 4 clocks per tick and 64 clocks per bit.
1. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> bitsRecibidos=8'hA5; recepcionFinalizada high exactly 1 cycle, 611+/-2 clocks after the raw falling edge; errorTrama stays 0; ocupado falls the same cycle.
2. Line low for 20 clocks, then high -> no strobe, bitsRecibidos unchanged, ocupado returns to 0 at mid start bit (~35 clocks).
3. Frame 0x3C with stop bit 0 -> errorTrama 1-cycle pulse, recepcionFinalizada 0, bitsRecibidos keeps its prior value 0xA5; a following good frame 0x7E (after line high) is received correctly.
4. Frames 0x01 and 0xFE back-to-back with a single stop bit and no idle -> two strobes 640 clocks apart, values 0x01 then 0xFE.
5. Assert reinicio low mid-DATOS of frame 0x55 -> all outputs 0 immediately, asynchronously; after release the rest of the frame produces no strobe; the next full frame 0x99 is received.
6. Hold line low through reset release -> no frame starts until a high-then-low edge occurs; then 0x42 is received correctly.
